// File: rtl/sd_spi_cmd_if.sv
// Command request/response handshake and SPI card pins for sd_spi_cmd.
// The master side issues commands; the slave side is the command engine.
interface sd_spi_cmd_if;
   logic        start;
   logic [5:0]  cmdIDX;
   logic [31:0] cmdARG;
   logic        rspLONG;
   logic        busy;
   logic        done;
   logic [7:0]  r1;
   logic [31:0] rspDATA;
   logic        timeout;
   logic        sdMISO;
   logic        sdMOSI;
   logic        sdSCLK;
   logic        sdCS;

   modport master (
      output start, cmdIDX, cmdARG, rspLONG, sdMISO,
      input  busy, done, r1, rspDATA, timeout, sdMOSI, sdSCLK, sdCS
   );

   modport slave (
      input  start, cmdIDX, cmdARG, rspLONG, sdMISO,
      output busy, done, r1, rspDATA, timeout, sdMOSI, sdSCLK, sdCS
   );
endinterface

// File: rtl/sd_spi_cmd.sv
// SD card SPI-mode command engine: sends one command frame, polls for R1,
// optionally reads a 4-byte trailer, then releases the card.
module sd_spi_cmd #(
   parameter int unsigned CLKDIV = 2,
   parameter int unsigned NCRMAX = 8
) (
   input  logic        clk,
   input  logic        reset,
   sd_spi_cmd_if.slave bus
);

   localparam int unsigned     CntW    = $clog2(NCRMAX + 8);
   localparam logic [7:0]      DivLast = 8'(CLKDIV - 1);
   localparam logic [CntW-1:0] NcrLast = CntW'(NCRMAX - 1);

   typedef enum logic [2:0] {StIdle, StPre, StCmd, StNcr, StRsp, StPost} state_e;

   state_e          state_q, state_d;
   logic [7:0]      div_q, div_d;
   logic [3:0]      phase_q, phase_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            gap_q, gap_d;
   logic            cs_q, cs_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            timeout_q, timeout_d;
   logic [7:0]      r1_q, r1_d;
   logic [31:0]     rsp_q, rsp_d;
   logic [5:0]      idx_q, idx_d;
   logic [31:0]     arg_q, arg_d;
   logic            long_q, long_d;

   logic [39:0]     crc_msg;
   logic [6:0]      crc;
   logic [7:0]      cmd_next;
   logic            byte_end;

   // CRC7 (x^7 + x^3 + 1) over the first five frame bytes, MSB first.
   always_comb begin
      crc_msg = {2'b01, idx_q, arg_q};
      crc     = '0;
      for (int i = 39; i >= 0; i--) begin
         crc = {crc[5:0], 1'b0} ^ ({7{crc[6] ^ crc_msg[i]}} & 7'h09);
      end
   end

   // Frame byte following CMD byte cnt_q.
   always_comb begin
      case (cnt_q)
         CntW'(0): cmd_next = arg_q[31:24];
         CntW'(1): cmd_next = arg_q[23:16];
         CntW'(2): cmd_next = arg_q[15:8];
         CntW'(3): cmd_next = arg_q[7:0];
         default:  cmd_next = {crc, 1'b1};
      endcase
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      phase_d   = phase_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      cs_d      = cs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      r1_d      = r1_q;
      rsp_d     = rsp_q;
      idx_d     = idx_q;
      arg_d     = arg_q;
      long_d    = long_q;
      byte_end  = 1'b0;

      if (state_q == StIdle) begin
         if (bus.start) begin
            idx_d     = bus.cmdIDX;
            arg_d     = bus.cmdARG;
            long_d    = bus.rspLONG;
            cs_d      = 1'b0;
            busy_d    = 1'b1;
            tx_d      = 8'hFF;
            r1_d      = 8'hFF;
            rsp_d     = '0;
            timeout_d = 1'b0;
            div_d     = '0;
            phase_d   = '0;
            cnt_d     = '0;
            state_d   = StPre;
         end
      end else if (state_q == StPost && gap_q) begin
         // One idle cycle with CS already high before the release byte.
         gap_d = 1'b0;
      end else if (div_q == DivLast) begin
         div_d   = '0;
         phase_d = phase_q + 4'd1;
         if (!phase_q[0]) begin
            rx_d = {rx_q[6:0], bus.sdMISO};
         end else if (phase_q != 4'd15) begin
            tx_d = {tx_q[6:0], 1'b1};
         end else begin
            byte_end = 1'b1;
         end
      end else begin
         div_d = div_q + 8'd1;
      end

      if (byte_end) begin
         tx_d  = 8'hFF;
         cnt_d = '0;
         case (state_q)
            StPre: begin
               tx_d    = {2'b01, idx_q};
               state_d = StCmd;
            end
            StCmd: begin
               if (cnt_q == CntW'(5)) begin
                  state_d = StNcr;
               end else begin
                  tx_d  = cmd_next;
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StNcr: begin
               if (!rx_q[7]) begin
                  r1_d    = rx_q;
                  state_d = long_q ? StRsp : StPost;
               end else if (cnt_q == NcrLast) begin
                  timeout_d = 1'b1;
                  r1_d      = 8'hFF;
                  state_d   = StPost;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StRsp: begin
               rsp_d = {rsp_q[23:0], rx_q};
               if (cnt_q == CntW'(3)) begin
                  state_d = StPost;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StPost: begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
            default: ;
         endcase
         if (state_d == StPost && state_q != StPost) begin
            cs_d  = 1'b1;
            gap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         div_q     <= '0;
         phase_q   <= '0;
         tx_q      <= 8'hFF;
         rx_q      <= '0;
         cnt_q     <= '0;
         gap_q     <= 1'b0;
         cs_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         r1_q      <= 8'hFF;
         rsp_q     <= '0;
         idx_q     <= '0;
         arg_q     <= '0;
         long_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         r1_q      <= r1_d;
         rsp_q     <= rsp_d;
         idx_q     <= idx_d;
         arg_q     <= arg_d;
         long_q    <= long_d;
      end
   end

   // SCLK is high during odd phases; MOSI is the MSB of the shift register.
   assign bus.sdSCLK  = phase_q[0];
   assign bus.sdMOSI  = tx_q[7];
   assign bus.sdCS    = cs_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.r1      = r1_q;
   assign bus.rspDATA = rsp_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Directed bench for sd_spi_cmd: instances with CLKDIV 2, 1 and 3 share one
// card model; only one instance is active at a time.
module tb_sd_spi_cmd;
   localparam int unsigned N      = 3;
   localparam int unsigned NCRMAX = 8;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic [N-1:0] start_v = '0;
   logic [5:0]   idx     = '0;
   logic [31:0]  arg     = '0;
   logic         lng     = 1'b0;
   logic         miso;
   logic [N-1:0] busy_v, done_v, to_v, mosi_v, sclk_v, cs_v;
   logic [7:0]   r1_v  [N];
   logic [31:0]  rsp_v [N];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned Div = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
      sd_spi_cmd_if u_if ();
      assign u_if.start   = start_v[g];
      assign u_if.cmdIDX  = idx;
      assign u_if.cmdARG  = arg;
      assign u_if.rspLONG = lng;
      assign u_if.sdMISO  = miso;
      assign busy_v[g]    = u_if.busy;
      assign done_v[g]    = u_if.done;
      assign to_v[g]      = u_if.timeout;
      assign mosi_v[g]    = u_if.sdMOSI;
      assign sclk_v[g]    = u_if.sdSCLK;
      assign cs_v[g]      = u_if.sdCS;
      assign r1_v[g]      = u_if.r1;
      assign rsp_v[g]     = u_if.rspDATA;
      sd_spi_cmd #(.CLKDIV(Div), .NCRMAX(NCRMAX)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (u_if)
      );
   end

   // Idle instances hold SCLK low, MOSI high and CS high, so the buses merge.
   logic sclk_any, cs_all, mosi_any;
   assign sclk_any = |sclk_v;
   assign cs_all   = &cs_v;
   assign mosi_any = &mosi_v;

   // Card: byte i of card_v (byte 0 in the top bits) is returned in frame byte i.
   logic [127:0] card_v = '1;
   logic [7:0]   fall_cnt = '0;
   always @(negedge sclk_any or posedge cs_all) begin
      if (cs_all) fall_cnt <= '0;
      else        fall_cnt <= fall_cnt + 8'd1;
   end
   assign miso = fall_cnt[7] ? 1'b1 : card_v[7'd127 - fall_cnt[6:0]];

   logic [6:0] msr = '0;
   int         mbits = 0;
   logic [7:0] mosi_q [$];
   always @(posedge sclk_any or negedge reset) begin
      if (!reset) begin
         mbits <= 0;
      end else if (mbits == 7) begin
         mosi_q.push_back({msr, mosi_any});
         mbits <= 0;
      end else begin
         msr   <= {msr[5:0], mosi_any};
         mbits <= mbits + 1;
      end
   end

   int   done_cnt   = 0;
   int   overlap    = 0;
   int   mode0_viol = 0;
   logic mosi_prev  = 1'b1;
   always @(negedge clk) begin
      done_cnt <= done_cnt + $countones(done_v);
      overlap  <= overlap + $countones(done_v & busy_v);
      if (mosi_any != mosi_prev && sclk_any) mode0_viol <= mode0_viol + 1;
      mosi_prev <= mosi_any;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] packed_mosi();
      logic [127:0] v;
      v = '0;
      foreach (mosi_q[i]) v = {v[119:0], mosi_q[i]};
      return v;
   endfunction

   task automatic run(input int k, input logic [5:0] i_idx, input logic [31:0] i_arg,
                      input logic i_lng, output int lat);
      logic busy1;
      busy1 = 1'b0;
      @(posedge clk);
      #1;
      idx        = i_idx;
      arg        = i_arg;
      lng        = i_lng;
      start_v[k] = 1'b1;
      mosi_q.delete();
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         start_v[k] = 1'b0;
         if (lat == 1) busy1 = busy_v[k];
      end while (!done_v[k] && lat < 3000);
      check("busy_after_start", busy1, 1);
      check("done_seen", done_v[k], 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      int           d0;
      int           div;
      int           t_first;
      int           t_second;
      logic [127:0] pm;

      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", cs_v[0], 1);
      check("rst_sclk", sclk_v[0], 0);
      check("rst_mosi", mosi_v[0], 1);
      check("rst_busy", busy_v[0], 0);
      check("rst_done", done_v[0], 0);
      check("rst_timeout", to_v[0], 0);
      check("rst_r1", r1_v[0], 8'hFF);
      check("rst_rsp", rsp_v[0], 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // CMD0, R1 on the first poll byte
      card_v = {{7{8'hFF}}, 8'h01, {8{8'hFF}}};
      d0 = done_cnt;
      run(0, 6'd0, 32'h0, 1'b0, lat);
      check("cmd0_r1", r1_v[0], 8'h01);
      check("cmd0_timeout", to_v[0], 0);
      check("cmd0_rsp", rsp_v[0], 32'h0);
      check("cmd0_cs_released", cs_v[0], 1);
      check("cmd0_latency", lat, 290);
      check("cmd0_mosi", packed_mosi(), 72'hFF_40_00_00_00_00_95_FF_FF);
      @(posedge clk);
      #1;
      check("cmd0_done_pulse", done_v[0], 0);
      check("cmd0_r1_held", r1_v[0], 8'h01);
      check("cmd0_done_count", done_cnt - d0, 1);

      // CMD8 with R7 trailer
      card_v = {{7{8'hFF}}, 40'h01_00_00_01_AA, {4{8'hFF}}};
      run(0, 6'd8, 32'h0000_01AA, 1'b1, lat);
      check("cmd8_r1", r1_v[0], 8'h01);
      check("cmd8_rsp", rsp_v[0], 32'h0000_01AA);
      check("cmd8_crc", mosi_q[6], 8'h87);
      check("cmd8_mosi", packed_mosi(), 104'hFF_48_00_00_01_AA_87_FF_FF_FF_FF_FF_FF);
      check("cmd8_latency", lat, 418);

      // CMD17, card silent: NCR timeout, trailer skipped despite rspLONG
      card_v = '1;
      run(0, 6'd17, 32'h0, 1'b1, lat);
      pm = packed_mosi();
      check("cmd17_timeout", to_v[0], 1);
      check("cmd17_r1", r1_v[0], 8'hFF);
      check("cmd17_rsp", rsp_v[0], 32'h0);
      check("cmd17_bytes", mosi_q.size(), 16);
      check("cmd17_hdr", mosi_q[1], 8'h51);
      check("cmd17_tail", pm[71:0], {9{8'hFF}});
      check("cmd17_latency", lat, 514);

      // CMD58 on the CLKDIV=1 and CLKDIV=3 instances
      for (int k = 1; k < 3; k++) begin
         div = (k == 1) ? 1 : 3;
         card_v = {{7{8'hFF}}, 40'h00_E0_FF_80_00, {4{8'hFF}}};
         run(k, 6'd58, 32'h0, 1'b1, lat);
         check("cmd58_r1", r1_v[k], 8'h00);
         check("cmd58_rsp", rsp_v[k], 32'hE0FF_8000);
         check("cmd58_timeout", to_v[k], 0);
         check("cmd58_hdr", mosi_q[1], 8'h7A);
         check("cmd58_long_latency", lat, 208 * div + 2);
         run(k, 6'd58, 32'h0, 1'b0, lat);
         check("cmd58_short_rsp", rsp_v[k], 32'h0);
         check("cmd58_short_latency", lat, 144 * div + 2);
      end

      // Reset asserted mid-CMD frame
      card_v = {{7{8'hFF}}, 8'h01, {8{8'hFF}}};
      @(posedge clk);
      #1;
      idx        = 6'd0;
      arg        = 32'h0;
      lng        = 1'b0;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (110) @(posedge clk);
      #2;
      check("abort_busy_before", busy_v[0], 1);
      check("abort_mosi_before", mosi_v[0], 0);
      d0    = done_cnt;
      reset = 1'b0;
      #1;
      check("abort_cs", cs_v[0], 1);
      check("abort_sclk", sclk_v[0], 0);
      check("abort_mosi", mosi_v[0], 1);
      check("abort_busy", busy_v[0], 0);
      check("abort_r1", r1_v[0], 8'hFF);
      check("abort_rsp", rsp_v[0], 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      run(0, 6'd0, 32'h0, 1'b0, lat);
      check("post_abort_mosi", packed_mosi(), 72'hFF_40_00_00_00_00_95_FF_FF);
      check("post_abort_r1", r1_v[0], 8'h01);
      check("post_abort_latency", lat, 290);

      // start held high: two back-to-back frames, then drop start
      @(posedge clk);
      #1;
      mosi_q.delete();
      d0         = done_cnt;
      t_first    = -1;
      t_second   = -1;
      start_v[0] = 1'b1;
      for (int c = 1; c <= 1500 && t_second < 0; c++) begin
         @(posedge clk);
         #1;
         if (done_v[0]) begin
            if (t_first < 0) begin
               t_first = c;
            end else begin
               t_second   = c;
               start_v[0] = 1'b0;
            end
         end
      end
      start_v[0] = 1'b0;
      check("b2b_first_done", t_first, 290);
      check("b2b_second_done", t_second, 580);
      repeat (400) @(posedge clk);
      #1;
      check("b2b_done_count", done_cnt - d0, 2);
      check("b2b_bytes", mosi_q.size(), 18);
      check("b2b_idle", busy_v[0], 0);

      check("busy_done_overlap", overlap, 0);
      check("mosi_while_sclk_high", mode0_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
